// File: rtl/serial_arith_pkg.sv
// Shared constants and helpers for the bit-serial arithmetic blocks:
// the controller state encoding and the bit-counter sizing rule.
package serial_arith_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   // Counter holds 0..width, so it never wraps before the last bit is seen.
   function automatic int cnt_width(input int width);
      return (width < 1) ? 1 : $clog2(width + 1);
   endfunction

endpackage

// File: rtl/half_subtractor.sv
// One-bit half subtractor: diff = a - b, borrow set when b exceeds a.
// Two of these plus an OR form a full-subtract bit cell.
module half_subtractor (
   input  logic a,
   input  logic b,
   output logic diff,
   output logic borrow
);

   assign diff   = a ^ b;
   assign borrow = ~a & b;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: diff = a - b, one bit per clock, LSB first,
// with valid/ready handshakes on the operand and result sides.
module serial_subtractor
   import serial_arith_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             borrow
);

   localparam int CW = cnt_width(WIDTH);

   logic [1:0]       state;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] diff_shift;
   logic [CW-1:0]    count;
   logic             borrow_q;
   logic             last_bit;

   logic             d0;
   logic             b0;
   logic             d;
   logic             b1;
   logic             bout;

   // Full-subtract cell: x - y first, then subtract the incoming borrow.
   half_subtractor u_hs_xy (
      .a      (a_sh[0]),
      .b      (b_sh[0]),
      .diff   (d0),
      .borrow (b0)
   );

   half_subtractor u_hs_bin (
      .a      (d0),
      .b      (borrow_q),
      .diff   (d),
      .borrow (b1)
   );

   assign bout     = b0 | b1;
   assign last_bit = (count == CW'(WIDTH - 1));

   assign in_ready  = (state == ST_IDLE);
   assign out_valid = (state == ST_DONE);

   // A one-bit result has no upper bits to shift down.
   generate
      if (WIDTH == 1) begin : g_narrow
         assign diff_shift = d;
      end else begin : g_wide
         assign diff_shift = {d, diff[WIDTH-1:1]};
      end
   endgenerate

   // NOTE: every flop here sits in one clocked block with non-blocking
   // updates, so the shift registers all move on the same edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ST_IDLE;
         a_sh     <= '0;
         b_sh     <= '0;
         diff     <= '0;
         borrow   <= 1'b0;
         borrow_q <= 1'b0;
         count    <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (in_valid) begin
                  a_sh     <= a;
                  b_sh     <= b;
                  borrow_q <= 1'b0;
                  count    <= '0;
                  state    <= ST_RUN;
               end
            end
            ST_RUN: begin
               diff     <= diff_shift;
               a_sh     <= a_sh >> 1;
               b_sh     <= b_sh >> 1;
               borrow_q <= bout;
               count    <= count + CW'(1);
               if (last_bit) begin
                  borrow <= bout;
                  state  <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: an 8-bit and a 1-bit instance driven with
// directed and random operands, checked against plain unsigned arithmetic.
module tb_serial_subtractor;

   logic       clk = 1'b0;
   logic       reset;

   logic       in_valid8, in_ready8, out_valid8, out_ready8, borrow8;
   logic [7:0] a8, b8, diff8;

   logic       in_valid1, in_ready1, out_valid1, out_ready1, borrow1;
   logic [0:0] a1, b1, diff1;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   serial_subtractor #(.WIDTH(8)) dut8 (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid8),
      .in_ready  (in_ready8),
      .a         (a8),
      .b         (b8),
      .out_valid (out_valid8),
      .out_ready (out_ready8),
      .diff      (diff8),
      .borrow    (borrow8)
   );

   serial_subtractor #(.WIDTH(1)) dut1 (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid1),
      .in_ready  (in_ready1),
      .a         (a1),
      .b         (b1),
      .out_valid (out_valid1),
      .out_ready (out_ready1),
      .diff      (diff1),
      .borrow    (borrow1)
   );

   task automatic check(input string tag, input logic [31:0] observed,
                        input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One full 8-bit transaction. stall = cycles out_ready stays low in DONE,
   // hold_ready keeps out_ready high throughout, next_valid leaves in_valid
   // asserted after acceptance (a following request already waiting).
   task automatic xact8(input logic [7:0] av, input logic [7:0] bv,
                        input int stall, input bit hold_ready,
                        input bit next_valid, input string tag);
      logic [7:0] exp_d;
      logic       exp_b;
      int         n;
      exp_d = av - bv;
      exp_b = (av < bv);
      a8 = av;
      b8 = bv;
      in_valid8 = 1'b1;
      if (hold_ready) out_ready8 = 1'b1;
      n = 0;
      while (!in_ready8 && n < 50) begin
         tick();
         n++;
      end
      check({tag, "/ready_before"}, in_ready8, 1);
      tick();
      in_valid8 = next_valid;
      check({tag, "/busy_after_accept"}, in_ready8, 0);
      n = 0;
      while (!out_valid8 && n < 50) begin
         tick();
         n++;
      end
      check({tag, "/latency"}, n, 8);
      check({tag, "/diff"}, diff8, exp_d);
      check({tag, "/borrow"}, borrow8, exp_b);
      if (!hold_ready) begin
         for (int i = 0; i < stall; i++) begin
            tick();
            check({tag, "/hold_valid"}, out_valid8, 1);
            check({tag, "/hold_in_ready"}, in_ready8, 0);
            check({tag, "/hold_diff"}, {diff8, borrow8}, {exp_d, exp_b});
         end
         out_ready8 = 1'b1;
      end
      tick();
      if (!hold_ready) out_ready8 = 1'b0;
      check({tag, "/valid_drop"}, out_valid8, 0);
      check({tag, "/ready_after"}, in_ready8, 1);
   endtask

   task automatic xact1(input logic av, input logic bv, input string tag);
      int n;
      a1 = av;
      b1 = bv;
      in_valid1 = 1'b1;
      check({tag, "/ready_before"}, in_ready1, 1);
      tick();
      in_valid1 = 1'b0;
      n = 0;
      while (!out_valid1 && n < 20) begin
         tick();
         n++;
      end
      check({tag, "/latency"}, n, 1);
      check({tag, "/diff"}, diff1, 1'(av - bv));
      check({tag, "/borrow"}, borrow1, (av < bv));
      out_ready1 = 1'b1;
      tick();
      out_ready1 = 1'b0;
      check({tag, "/valid_drop"}, out_valid1, 0);
   endtask

   initial begin
      bit seen;
      reset = 1'b1;
      {in_valid8, out_ready8, a8, b8} = '0;
      {in_valid1, out_ready1, a1, b1} = '0;
      tick();
      tick();
      check("reset/in_ready8", in_ready8, 1);
      check("reset/out_valid8", out_valid8, 0);
      check("reset/result8", {diff8, borrow8}, 0);
      check("reset/in_ready1", in_ready1, 1);
      check("reset/result1", {out_valid1, diff1, borrow1}, 0);
      reset = 1'b0;

      xact8(8'h5A, 8'h3C, 0, 1'b1, 1'b0, "basic");
      out_ready8 = 1'b0;
      xact8(8'h00, 8'h01, 0, 1'b0, 1'b0, "underflow");
      xact8(8'hFF, 8'hFF, 0, 1'b0, 1'b0, "equal");

      xact8(8'h80, 8'h01, 6, 1'b0, 1'b1, "backpressure");
      xact8(8'h12, 8'h34, 0, 1'b0, 1'b0, "after_bp");

      // Abort an operation during its 4th RUN cycle.
      a8 = 8'hC3;
      b8 = 8'h5A;
      in_valid8 = 1'b1;
      tick();
      in_valid8 = 1'b0;
      check("abort/accepted", in_ready8, 0);
      repeat (3) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("abort/in_ready", in_ready8, 1);
      check("abort/out_valid", out_valid8, 0);
      check("abort/result", {diff8, borrow8}, 0);
      seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (out_valid8) seen = 1'b1;
      end
      check("abort/no_pulse", seen, 0);

      xact8(8'd10, 8'd3, 0, 1'b1, 1'b1, "b2b_0");
      xact8(8'd3, 8'd10, 0, 1'b1, 1'b1, "b2b_1");
      xact8(8'd200, 8'd200, 0, 1'b1, 1'b0, "b2b_2");
      out_ready8 = 1'b0;

      xact1(1'b0, 1'b0, "w1_00");
      xact1(1'b0, 1'b1, "w1_01");
      xact1(1'b1, 1'b0, "w1_10");
      xact1(1'b1, 1'b1, "w1_11");

      for (int i = 0; i < 24; i++) begin
         xact8(8'($urandom), 8'($urandom), int'($urandom_range(0, 2)),
               1'b0, 1'b0, "random");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
